// File: rtl/sqrt_sched.sv
`default_nettype none
// ============================================================================
// Module   : sqrt_sched
// Brief    : Round-robin scheduler sharing one pipelined sqrt_int unit among
//            NUM_REQ requesters, with requester-ID tagging and halt/drain.
//            Optional per-requester grant counters: SQRT_SCHED_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sqrt_sched #(
    parameter int  DATAWIDTH    = 8,
    parameter int  NUM_REQ      = 4,
    parameter int  PIPE_LATENCY = 2,
    localparam int IDW          = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATAWIDTH-1:0] req_rad,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         sq_i_valid,
    output logic [DATAWIDTH-1:0]         sq_rad,
    input  logic                         sq_o_valid,
    input  logic [DATAWIDTH-1:0]         sq_root,
    input  logic [DATAWIDTH-1:0]         sq_rem,
    output logic                         rsp_valid,
    output logic [IDW-1:0]               rsp_id,
    output logic [DATAWIDTH-1:0]         rsp_root,
    output logic [DATAWIDTH-1:0]         rsp_rem,
    input  logic                         halt_req,
    output logic                         halted,
    output logic                         err
`ifdef SQRT_SCHED_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]        grant_cnt
`endif
);

    localparam logic [1:0]   c_RUN     = 2'd0;
    localparam logic [1:0]   c_DRAIN   = 2'd1;
    localparam logic [1:0]   c_HALTED  = 2'd2;
    localparam logic [IDW:0] c_NUM_REQ = (IDW+1)'(NUM_REQ);

    logic [1:0]                       r_state;
    logic [1:0]                       w_state_nxt;
    logic [IDW-1:0]                   r_rr_ptr;
    logic [IDW:0]                     w_sum;
    logic [IDW-1:0]                   w_idx;
    logic                             w_found;
    logic                             w_grant_en;
    logic                             w_accept;
    logic                             w_inflight;
    logic [NUM_REQ-1:0]               w_ready;
    logic [IDW-1:0]                   w_gnt_id;
    logic [IDW:0]                     w_ptr_inc;
    logic [IDW-1:0]                   w_ptr_nxt;
    logic [DATAWIDTH-1:0]             w_acc_rad;

    logic                             r_sq_i_valid;
    logic [DATAWIDTH-1:0]             r_sq_rad;
    logic [IDW-1:0]                   r_issue_id;
    logic [PIPE_LATENCY-1:0]          r_tag_vld;
    logic [PIPE_LATENCY-1:0][IDW-1:0] r_tag_id;

    logic                             r_rsp_valid;
    logic [IDW-1:0]                   r_rsp_id;
    logic [DATAWIDTH-1:0]             r_rsp_root;
    logic [DATAWIDTH-1:0]             r_rsp_rem;
    logic                             r_err;

    // Grants stop in the same cycle halt_req rises, and never during reset.
    assign w_grant_en = (r_state == c_RUN) && !halt_req && !rst;

    always_comb begin
        w_ready = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (IDW+1)'(k);
            if (w_sum >= c_NUM_REQ) begin
                w_sum = w_sum - c_NUM_REQ;
            end
            w_idx = w_sum[IDW-1:0];
            if (w_grant_en && !w_found && req_valid[w_idx]) begin
                w_found        = 1'b1;
                w_ready[w_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        w_gnt_id  = '0;
        w_acc_rad = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_ready[i]) begin
                w_gnt_id  = IDW'(i);
                w_acc_rad = req_rad[i*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    assign w_accept  = |w_ready;
    assign w_ptr_inc = {1'b0, w_gnt_id} + (IDW+1)'(1);
    assign w_ptr_nxt = (w_ptr_inc == c_NUM_REQ) ? '0 : w_ptr_inc[IDW-1:0];

    // The response register is not counted: its op has already left the unit.
    assign w_inflight = r_sq_i_valid || (|r_tag_vld);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_RUN: begin
                if (halt_req) begin
                    w_state_nxt = c_DRAIN;
                end
            end
            c_DRAIN: begin
                if (!halt_req) begin
                    w_state_nxt = c_RUN;
                end else if (!w_inflight) begin
                    w_state_nxt = c_HALTED;
                end
            end
            c_HALTED: begin
                if (!halt_req) begin
                    w_state_nxt = c_RUN;
                end
            end
            default: w_state_nxt = c_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_RUN;
            r_rr_ptr     <= '0;
            r_sq_i_valid <= 1'b0;
            r_sq_rad     <= '0;
            r_issue_id   <= '0;
            r_tag_vld    <= '0;
            r_tag_id     <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_root   <= '0;
            r_rsp_rem    <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sq_i_valid <= w_accept;
            if (w_accept) begin
                r_rr_ptr   <= w_ptr_nxt;
                r_sq_rad   <= w_acc_rad;
                r_issue_id <= w_gnt_id;
            end
            // Tag stage k is valid in the same cycle the unit is k+1 cycles past i_valid.
            r_tag_vld[0] <= r_sq_i_valid;
            r_tag_id[0]  <= r_issue_id;
            for (int k = 1; k < PIPE_LATENCY; k++) begin
                r_tag_vld[k] <= r_tag_vld[k-1];
                r_tag_id[k]  <= r_tag_id[k-1];
            end
            r_rsp_valid <= sq_o_valid;
            if (sq_o_valid) begin
                r_rsp_id   <= r_tag_id[PIPE_LATENCY-1];
                r_rsp_root <= sq_root;
                r_rsp_rem  <= sq_rem;
            end
            if (sq_o_valid != r_tag_vld[PIPE_LATENCY-1]) begin
                r_err <= 1'b1;
            end
        end
    end

    assign req_ready  = w_ready;
    assign sq_i_valid = r_sq_i_valid;
    assign sq_rad     = r_sq_rad;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_root   = r_rsp_root;
    assign rsp_rem    = r_rsp_rem;
    assign halted     = (r_state == c_HALTED);
    assign err        = r_err;

`ifdef SQRT_SCHED_STATS_EN
    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
            logic [15:0] r_cnt;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (w_ready[g] && (r_cnt != 16'hFFFF)) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
            assign grant_cnt[g*16 +: 16] = r_cnt;
        end
    endgenerate
`endif

endmodule
`default_nettype wire
